// File: rtl/deadlock_mon_pkg.sv
// Shared constants and helpers for the kernel deadlock monitor.
package deadlock_mon_pkg;

  localparam int unsigned DEFAULT_N_AXIS    = 4;
  localparam int unsigned DEFAULT_N_INST    = 1;
  localparam int unsigned DEFAULT_THRESHOLD = 64;

  // Ceiling log2; callers pass THRESHOLD+1, so the result is never 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/deadlock_persist_counter.sv
// Saturating persistence counter: hit rises once cond has held for THRESHOLD edges.
module deadlock_persist_counter
  import deadlock_mon_pkg::*;
#(
  parameter int unsigned THRESHOLD = DEFAULT_THRESHOLD
) (
  input  logic clock,
  input  logic reset,
  input  logic cond,
  output logic hit
);

  localparam int unsigned CNT_W = clog2(THRESHOLD + 1);
  localparam logic [CNT_W-1:0] THR    = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESHOLD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_hit;
  logic             w_near;

  // cnt never exceeds THRESHOLD, so ">= THRESHOLD-1" reduces to these two values.
  assign w_near = (r_cnt == THR_M1) || (r_cnt == THR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_hit <= 1'b0;
    end else begin
      r_hit <= cond && w_near;
      if (!cond) begin
        r_cnt <= '0;
      end else if (r_cnt != THR) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign hit = r_hit;

endmodule

// File: rtl/deadlock_idx0_monitor.sv
// Kernel deadlock detector: every process idle or stream-stalled, with at least
// one real stall, for THRESHOLD consecutive edges.
module deadlock_idx0_monitor
  import deadlock_mon_pkg::*;
#(
  parameter int unsigned N_AXIS    = DEFAULT_N_AXIS,
  parameter int unsigned N_INST    = DEFAULT_N_INST,
  parameter int unsigned THRESHOLD = DEFAULT_THRESHOLD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_AXIS-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  output logic              block
);

  logic w_quiet;
  logic w_stalled;
  logic w_cond;

  // A fully idle kernel is finished, not deadlocked: require a genuine stall.
  assign w_quiet   = &(axis_block_sigs | inst_idle_sigs);
  assign w_stalled = (|axis_block_sigs) || (|inst_block_sigs);
  assign w_cond    = w_quiet && w_stalled;

  deadlock_persist_counter #(
    .THRESHOLD(THRESHOLD)
  ) u_persist (
    .clock(clock),
    .reset(reset),
    .cond (w_cond),
    .hit  (block)
  );

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Directed self-checking bench for deadlock_idx0_monitor (THRESHOLD=64 and THRESHOLD=1).
module tb_deadlock_idx0_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] axis_a = '0, idle_a = '0;
  logic [0:0] inst_a = '0;
  logic       block_a;
  logic [3:0] axis_b = '0, idle_b = '0;
  logic [0:0] inst_b = '0;
  logic       block_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  deadlock_idx0_monitor #(.N_AXIS(4), .N_INST(1), .THRESHOLD(64)) dut (
    .clock(clock), .reset(reset),
    .axis_block_sigs(axis_a), .inst_idle_sigs(idle_a), .inst_block_sigs(inst_a),
    .block(block_a)
  );

  deadlock_idx0_monitor #(.N_AXIS(4), .N_INST(1), .THRESHOLD(1)) dut1 (
    .clock(clock), .reset(reset),
    .axis_block_sigs(axis_b), .inst_idle_sigs(idle_b), .inst_block_sigs(inst_b),
    .block(block_b)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Hold current inputs; block stays 0 for 63 edges and rises on the 64th.
  task automatic expect_rise64(input string tag);
    for (int k = 1; k <= 64; k++) begin
      step();
      if (k == 1 || k == 63 || k == 64) check(tag, block_a, (k == 64) ? 1'b1 : 1'b0);
      else if (block_a !== 1'b0) check(tag, block_a, 1'b0);
    end
  endtask

  logic [7:0] pat;

  initial begin
    // Reset held with all inputs low.
    for (int k = 0; k < 100; k++) begin
      step();
      if (k % 25 == 0) begin
        check("reset_a", block_a, 1'b0);
        check("reset_b", block_b, 1'b0);
      end
    end
    reset = 1'b0;
    step();
    check("post_reset_a", block_a, 1'b0);

    // One stalled channel, the rest idle.
    axis_a = 4'b0001; idle_a = 4'b1110; inst_a = 1'b0;
    expect_rise64("hold_rise");
    for (int k = 0; k < 200; k++) begin
      step();
      if (k % 50 == 0 || k == 199) check("hold_stay", block_a, 1'b1);
    end
    axis_a = 4'b0000;
    step();
    check("fall_nonsticky", block_a, 1'b0);
    step();

    // One-cycle glitch at edge 30 restarts the whole count.
    axis_a = 4'b0001; idle_a = 4'b1110;
    for (int k = 1; k <= 29; k++) step();
    check("glitch_pre", block_a, 1'b0);
    idle_a = 4'b1010;
    step();
    check("glitch_edge", block_a, 1'b0);
    idle_a = 4'b1110;
    expect_rise64("glitch_restart");
    axis_a = 4'b0000;
    step();
    check("glitch_fall", block_a, 1'b0);

    // No stall anywhere: never a deadlock, even when every process is idle.
    axis_a = 4'b0000; idle_a = 4'b1110; inst_a = 1'b0;
    for (int k = 0; k < 500; k++) begin
      step();
      if (k % 100 == 0 || k == 499) check("no_stall", block_a, 1'b0);
    end
    idle_a = 4'b1111;
    for (int k = 0; k < 100; k++) step();
    check("all_idle_finished", block_a, 1'b0);
    idle_a = 4'b1110;

    // Instance block together with a stream stall.
    inst_a = 1'b1; axis_a = 4'b0001;
    expect_rise64("inst_block_rise");

    // Asynchronous reset mid-cycle while BLOCKED.
    #2 reset = 1'b1;
    #1 check("async_reset_drop", block_a, 1'b0);
    #3 reset = 1'b0;
    expect_rise64("after_async_reset");
    inst_a = 1'b0; axis_a = 4'b0000;
    step();
    check("final_fall", block_a, 1'b0);

    // THRESHOLD=1: block is cond delayed by one edge.
    idle_b = 4'b1110; inst_b = 1'b0;
    pat = 8'b0100_1101;
    for (int k = 0; k < 8; k++) begin
      axis_b = {3'b000, pat[k]};
      step();
      check("thr1_follow", block_b, pat[k]);
    end
    axis_b = 4'b0000;
    step();
    check("thr1_clear", block_b, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
